bound_flasher_monitor: RTL
==========================

BOUND_FLASHER_MONITOR -- requirements
Module: bound_flasher_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-cycle counter.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port LED  input  16  observed flasher bar; bit 0 is the lowest lamp.
REQ-005 SHALL have port FLICK  input  1  observed flick request, sampled every rising edge.
REQ-006 SHALL have port LEVEL  output  5  number of lit lamps decoded from LED (0..16).
REQ-007 SHALL have port DIR  output  2  tracked direction: 0 IDLE, 1 UP, 2 DOWN, 3 SYNC.
REQ-008 SHALL have port PHASE  output  2  tracked bound phase, 0..2.
REQ-009 SHALL have port KICK  output  1  one-cycle pulse when a legal kickback is observed.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse when a full three-phase sequence ends at LED=0.
REQ-011 SHALL have port DONE_CNT  output  CNT_W  count of DONE pulses, saturating at all-ones.
REQ-012 SHALL have port ERR  output  1  sticky protocol-violation flag.
REQ-013 SHALL have port ERR_CODE  output  3  code of the first violation since reset; 0 = none.

Function
REQ-014 SHALL evaluate at each rising edge the current LED (level L) against LED captured at the previous edge (level P); all outputs SHALL be registered, reflecting the evaluation one edge after sampling.
REQ-015 SHALL treat LED as legal only when of the form 2^n-1 (n=0..16); otherwise error code 1 (NOT_THERMO), LEVEL SHALL then hold its previous value.
REQ-016 SHALL flag code 2 (JUMP) when |L-P| > 1.
REQ-017 SHALL use bound tables: max level per phase 16/11/6, min level per phase 6/1/1.
REQ-018 IDLE: L=0 stays; L=1 -> UP with PHASE=0; any other L -> code 7 (BAD_START).
REQ-019 UP: L=P+1 stays UP, L>max[PHASE] -> code 3 (BAD_PEAK); L=P-1 -> DOWN, legal only if P=max[PHASE], else code 3; L=P -> code 5 (STALL).
REQ-020 DOWN, L=P-1: stays DOWN; if L<min[PHASE] and not (PHASE=2, L=0) -> code 6 (BAD_EXIT).
REQ-021 DOWN, PHASE=2, P=1, L=0 -> IDLE, PHASE=0, DONE pulse, DONE_CNT+1.
REQ-022 DOWN, L=P+1: legal only if P=min[PHASE] and PHASE<2 -> UP, PHASE+1; else code 4 (BAD_TURN).
REQ-023 DOWN, L=P: legal only if P in {1,6} and FLICK was 1 at the current or previous edge -> KICK pulse, UP, PHASE-1 saturating at 0; else code 5.
REQ-024 Any violation SHALL set ERR, load ERR_CODE only if it is 0, and move DIR to SYNC.
REQ-025 SYNC SHALL wait for L=0 then go to IDLE with PHASE=0; ERR/ERR_CODE SHALL remain until RST.
REQ-026 When several violations arise at one edge, the lowest code SHALL be recorded.
REQ-027 KICK and DONE SHALL never assert in the same cycle nor while DIR=SYNC.

Reset
REQ-028 RST=1 at a rising edge SHALL set LEVEL=0, DIR=IDLE, PHASE=0, KICK=0, DONE=0, DONE_CNT=0, ERR=0, ERR_CODE=0, captured LED=0, FLICK history=0; RST SHALL override all other events including mid-sequence.

Verification
REQ-029 Full legal sequence 0->16->6->11->1->6->0 one step per cycle -> single DONE on the 1->0 edge, DONE_CNT=1, ERR=0, no KICK.
REQ-030 Phase 1 descending, hold at level 6 with FLICK=1 one cycle, then rise to 16 -> KICK one cycle, PHASE=0, DIR=UP, ERR=0.
REQ-031 LED=16'h0005 mid-UP -> ERR=1, ERR_CODE=1, DIR=SYNC; later LED=0 -> DIR=IDLE, ERR stays 1.
REQ-032 Phase 0 UP turning at level 15 (15->14) -> ERR_CODE=3; later JUMP 4->6 -> ERR_CODE stays 3.
REQ-033 DOWN hold at level 9 with FLICK=1 -> ERR_CODE=5; hold at level 1 with FLICK=0 -> ERR_CODE=5.
REQ-034 RST=1 for one edge in phase 2 DOWN with ERR=1 -> all outputs reset values next cycle; DONE_CNT=0.

Source files
------------

// File: rtl/bound_flasher_monitor_if.sv
// Observation bus between a bound flasher and its protocol monitor.
// The master side drives the observed lamps and flick; the slave side reports tracking status.
interface bound_flasher_monitor_if #(
    parameter int CNT_W = 8
);
    logic [15:0]      LED;
    logic             FLICK;
    logic [4:0]       LEVEL;
    logic [1:0]       DIR;
    logic [1:0]       PHASE;
    logic             KICK;
    logic             DONE;
    logic [CNT_W-1:0] DONE_CNT;
    logic             ERR;
    logic [2:0]       ERR_CODE;

    modport master (
        output LED, FLICK,
        input  LEVEL, DIR, PHASE, KICK, DONE, DONE_CNT, ERR, ERR_CODE
    );

    modport slave (
        input  LED, FLICK,
        output LEVEL, DIR, PHASE, KICK, DONE, DONE_CNT, ERR, ERR_CODE
    );
endinterface

// File: rtl/bound_flasher_monitor.sv
// Tracks a bound flasher's lamp bar edge by edge and flags any departure from its legal
// three-phase up/down sequence.
//
// state | meaning
// IDLE  | bar dark, waiting for the first lamp
// UP    | bar climbing toward the phase maximum
// DOWN  | bar falling toward the phase minimum
// SYNC  | violation seen, waiting for a dark bar to resynchronise
module bound_flasher_monitor #(
    parameter int CNT_W = 8
) (
    input logic                   CLK,
    input logic                   RST,
    bound_flasher_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, SYNC = 2'd3} dir_t;

    dir_t             dir_q, dir_d;
    logic [1:0]       phase_q, phase_d;
    logic [4:0]       level_q, level_d;
    logic             kick_q, kick_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [2:0]       code_q, code_d;
    logic             flick_q;

    logic             thermo;
    logic [4:0]       cur;
    logic [4:0]       max_l, min_l;
    logic             up_step, dn_step, hold;
    logic             flick_any;
    logic [2:0]       viol;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dir_q   <= IDLE;
            phase_q <= 2'd0;
            level_q <= 5'd0;
            kick_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
            flick_q <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            phase_q <= phase_d;
            level_q <= level_d;
            kick_q  <= kick_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
            flick_q <= bus.FLICK;
        end
    end

    always_comb begin
        thermo = ((bus.LED & (bus.LED + 16'd1)) == 16'd0);
        cur = 5'd0;
        for (int i = 0; i < 16; i++) cur = cur + 5'(bus.LED[i]);

        case (phase_q)
            2'd0:    begin max_l = 5'd16; min_l = 5'd6; end
            2'd1:    begin max_l = 5'd11; min_l = 5'd1; end
            default: begin max_l = 5'd6;  min_l = 5'd1; end
        endcase

        // level_q is the last legal level, i.e. the previous edge's bar
        up_step   = (cur == level_q + 5'd1);
        dn_step   = (cur + 5'd1 == level_q);
        hold      = (cur == level_q);
        flick_any = bus.FLICK | flick_q;

        dir_d   = dir_q;
        phase_d = phase_q;
        level_d = thermo ? cur : level_q;
        kick_d  = 1'b0;
        done_d  = 1'b0;
        viol    = 3'd0;

        if (dir_q == SYNC) begin
            if (bus.LED == 16'd0) begin
                dir_d   = IDLE;
                phase_d = 2'd0;
            end
        end else if (!thermo) begin
            viol = 3'd1;
        end else if (!(up_step || dn_step || hold)) begin
            viol = 3'd2;
        end else begin
            case (dir_q)
                IDLE: begin
                    if (cur == 5'd1) begin
                        dir_d   = UP;
                        phase_d = 2'd0;
                    end else if (cur != 5'd0) begin
                        viol = 3'd7;
                    end
                end
                UP: begin
                    if (up_step) begin
                        if (cur > max_l) viol = 3'd3;
                    end else if (dn_step) begin
                        if (level_q == max_l) dir_d = DOWN;
                        else                  viol  = 3'd3;
                    end else begin
                        viol = 3'd5;
                    end
                end
                DOWN: begin
                    if (dn_step) begin
                        if (phase_q == 2'd2 && cur == 5'd0) begin
                            dir_d   = IDLE;
                            phase_d = 2'd0;
                            done_d  = 1'b1;
                        end else if (cur < min_l) begin
                            viol = 3'd6;
                        end
                    end else if (up_step) begin
                        if (level_q == min_l && phase_q != 2'd2) begin
                            dir_d   = UP;
                            phase_d = phase_q + 2'd1;
                        end else begin
                            viol = 3'd4;
                        end
                    end else begin
                        if ((level_q == 5'd1 || level_q == 5'd6) && flick_any) begin
                            kick_d  = 1'b1;
                            dir_d   = UP;
                            phase_d = (phase_q == 2'd0) ? 2'd0 : phase_q - 2'd1;
                        end else begin
                            viol = 3'd5;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (viol != 3'd0) begin
            dir_d   = SYNC;
            phase_d = phase_q;
            kick_d  = 1'b0;
            done_d  = 1'b0;
        end

        err_d  = err_q | (viol != 3'd0);
        code_d = (code_q == 3'd0) ? viol : code_q;
        cnt_d  = (done_d && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    assign bus.LEVEL    = level_q;
    assign bus.DIR      = dir_q;
    assign bus.PHASE    = phase_q;
    assign bus.KICK     = kick_q;
    assign bus.DONE     = done_q;
    assign bus.DONE_CNT = cnt_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_CODE = code_q;
endmodule
